// File: rtl/overlap_window_writer.sv
// Purpose: packs IMDCT samples in pairs and writes whole windows into a ring of slots in the overlap/add sample RAM.
// Latency: RAM write is registered, valid the cycle after the odd sample is accepted; seq_done shares that cycle with the final write.
// Backpressure: sample_ready drops only at a window boundary when every slot is occupied, and returns one cycle after a slot is freed.
module overlap_window_writer #(
   parameter int windowSize = 1024,
   parameter int wordLength = 16,
   parameter int numSlots   = 3,
   parameter int addrWidth  = 11
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [wordLength-1:0]   sample_in,
   input  logic                    sample_valid,
   output logic                    sample_ready,
   output logic                    mem_wr_en,
   output logic [addrWidth-1:0]    mem_wr_addr,
   output logic [2*wordLength-1:0] mem_wr_data,
   output logic                    seq_done,
   output logic [1:0]              seq_slot,
   output logic [15:0]             seq_count,
   input  logic                    seq_release,
   output logic [1:0]              slots_used
);

   localparam int HALF  = windowSize / 2;
   localparam int IDX_W = (HALF > 1) ? $clog2(HALF) : 1;

   localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(HALF - 1);
   localparam logic [1:0]           LAST_SLOT  = 2'(numSlots - 1);
   localparam logic [2:0]           NUM_SLOTS3 = 3'(numSlots);
   localparam logic [addrWidth-1:0] HALF_A     = addrWidth'(HALF);

   typedef enum logic [1:0] {
      FILL_LO = 2'd0,
      FILL_HI = 2'd1,
      WAIT    = 2'd2
   } state_t;

   state_t                  r_state;
   logic [wordLength-1:0]   r_lo;
   logic [IDX_W-1:0]        r_word_idx;
   logic [1:0]              r_wr_slot;
   logic [1:0]              r_slots_used;
   logic                    r_mem_wr_en;
   logic [addrWidth-1:0]    r_mem_wr_addr;
   logic [2*wordLength-1:0] r_mem_wr_data;
   logic                    r_seq_done;
   logic [1:0]              r_seq_slot;
   logic [15:0]             r_seq_count;

   logic                    w_ready;
   logic                    w_accept;
   logic                    w_write;
   logic                    w_last_word;
   logic                    w_complete;
   logic                    w_release;
   logic [2:0]              w_slots_next;
   logic [addrWidth-1:0]    w_addr;

   // Handshake and window-boundary decode; a release against an empty ring is dropped.
   assign w_ready     = (r_state != WAIT);
   assign w_accept    = sample_valid && w_ready;
   assign w_write     = w_accept && (r_state == FILL_HI);
   assign w_last_word = (r_word_idx == LAST_IDX);
   assign w_complete  = w_write && w_last_word;
   assign w_release   = seq_release && (r_slots_used != 2'd0);

   // Word address of the pair being written: slot base plus word offset inside the window.
   assign w_addr = ({{(addrWidth-2){1'b0}}, r_wr_slot} * HALF_A)
                 + {{(addrWidth-IDX_W){1'b0}}, r_word_idx};

   // Net occupancy after this edge; a completion and a release in the same cycle cancel.
   always_comb begin
      w_slots_next = {1'b0, r_slots_used};
      if (w_complete && !w_release) begin
         w_slots_next = {1'b0, r_slots_used} + 3'd1;
      end else if (w_release && !w_complete) begin
         w_slots_next = {1'b0, r_slots_used} - 3'd1;
      end
   end

   // Fill state machine: latches the even sample, steps word index and slot, parks in WAIT when the ring is full.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= FILL_LO;
         r_lo       <= '0;
         r_word_idx <= '0;
         r_wr_slot  <= 2'd0;
      end else begin
         case (r_state)
            FILL_LO: begin
               if (w_accept) begin
                  r_lo    <= sample_in;
                  r_state <= FILL_HI;
               end
            end
            FILL_HI: begin
               if (w_accept) begin
                  if (w_last_word) begin
                     r_word_idx <= '0;
                     r_wr_slot  <= (r_wr_slot == LAST_SLOT) ? 2'd0 : r_wr_slot + 2'd1;
                     r_state    <= (w_slots_next < NUM_SLOTS3) ? FILL_LO : WAIT;
                  end else begin
                     r_word_idx <= r_word_idx + 1'b1;
                     r_state    <= FILL_LO;
                  end
               end
            end
            WAIT: begin
               if ({1'b0, r_slots_used} < NUM_SLOTS3) begin
                  r_state <= FILL_LO;
               end
            end
            default: begin
               r_state <= FILL_LO;
            end
         endcase
      end
   end

   // RAM write port: one-cycle strobe, address and packed pair held between writes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mem_wr_en   <= 1'b0;
         r_mem_wr_addr <= '0;
         r_mem_wr_data <= '0;
      end else begin
         r_mem_wr_en <= w_write;
         if (w_write) begin
            r_mem_wr_addr <= w_addr;
            r_mem_wr_data <= {sample_in, r_lo};
         end
      end
   end

   // Sequence bookkeeping: completion pulse, completed slot, running count and ring occupancy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_seq_done   <= 1'b0;
         r_seq_slot   <= 2'd0;
         r_seq_count  <= 16'd0;
         r_slots_used <= 2'd0;
      end else begin
         r_seq_done   <= w_complete;
         r_slots_used <= w_slots_next[1:0];
         if (w_complete) begin
            r_seq_slot  <= r_wr_slot;
            r_seq_count <= r_seq_count + 16'd1;
         end
      end
   end

   assign sample_ready = w_ready;
   assign mem_wr_en    = r_mem_wr_en;
   assign mem_wr_addr  = r_mem_wr_addr;
   assign mem_wr_data  = r_mem_wr_data;
   assign seq_done     = r_seq_done;
   assign seq_slot     = r_seq_slot;
   assign seq_count    = r_seq_count;
   assign slots_used   = r_slots_used;

endmodule

// File: tb/tb_overlap_window_writer.sv
// Purpose: randomized and directed stimulus for overlap_window_writer against a window-level reference model.
// Latency: expected writes are queued when the odd sample is issued and compared when the DUT strobes the RAM.
// Backpressure: acceptance is predicted by the model; DUT sample_ready is compared against that prediction every cycle.
module tb_overlap_window_writer;

   localparam int W    = 1024;
   localparam int HALF = W / 2;
   localparam int NS   = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] sample_in = 16'd0;
   logic        sample_valid = 1'b0;
   logic        seq_release = 1'b0;
   logic        sample_ready;
   logic        mem_wr_en;
   logic [10:0] mem_wr_addr;
   logic [31:0] mem_wr_data;
   logic        seq_done;
   logic [1:0]  seq_slot;
   logic [15:0] seq_count;
   logic [1:0]  slots_used;

   overlap_window_writer #(
      .windowSize(W),
      .wordLength(16),
      .numSlots(NS),
      .addrWidth(11)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sample_in(sample_in),
      .sample_valid(sample_valid),
      .sample_ready(sample_ready),
      .mem_wr_en(mem_wr_en),
      .mem_wr_addr(mem_wr_addr),
      .mem_wr_data(mem_wr_data),
      .seq_done(seq_done),
      .seq_slot(seq_slot),
      .seq_count(seq_count),
      .seq_release(seq_release),
      .slots_used(slots_used)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [10:0] addr;
      logic [31:0] data;
      logic        done;
      logic [1:0]  slot;
      logic [15:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   int checks   = 0;
   int failures = 0;

   // Reference model state: counts of windows and samples, not the RTL encoding.
   bit          m_wait;
   int          m_used;
   int          m_pos;
   int          m_win;
   int          m_cnt;
   logic [1:0]  m_last_slot;
   logic [15:0] m_val = 16'd0;
   logic [15:0] m_lo;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic model_reset();
      m_wait      = 1'b0;
      m_used      = 0;
      m_pos       = 0;
      m_win       = 0;
      m_cnt       = 0;
      m_last_slot = 2'd0;
      m_lo        = 16'd0;
      exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"},     64'(sample_ready), 64'd1);
      chk({tag, "_wr_en"},     64'(mem_wr_en),    64'd0);
      chk({tag, "_wr_addr"},   64'(mem_wr_addr),  64'd0);
      chk({tag, "_wr_data"},   64'(mem_wr_data),  64'd0);
      chk({tag, "_seq_done"},  64'(seq_done),     64'd0);
      chk({tag, "_seq_slot"},  64'(seq_slot),     64'd0);
      chk({tag, "_seq_count"}, 64'(seq_count),    64'd0);
      chk({tag, "_used"},      64'(slots_used),   64'd0);
   endtask

   // One clock of stimulus: check ready/occupancy, drive inputs, advance the model across the coming edge.
   task automatic step(input bit v, input bit rel);
      bit acc;
      bit cmp;
      bit rel_eff;
      bit rdy;
      int nu;
      int cur;
      exp_t e;
      @(negedge clk);
      rdy = !m_wait;
      chk("sample_ready", 64'(sample_ready), 64'(rdy));
      chk("slots_used",   64'(slots_used),   64'(m_used));
      sample_valid = v;
      sample_in    = v ? m_val : 16'($urandom);
      seq_release  = rel;
      acc     = v && rdy;
      rel_eff = rel && (m_used != 0);
      cmp     = acc && (m_pos == W - 1);
      cur     = m_win % NS;
      if (acc) begin
         if ((m_pos % 2) == 0) begin
            m_lo = m_val;
         end else begin
            e.addr = 11'(cur * HALF + m_pos / 2);
            e.data = {m_val, m_lo};
            e.done = cmp;
            e.slot = cmp ? 2'(cur) : m_last_slot;
            e.cnt  = 16'(m_cnt + (cmp ? 1 : 0));
            exp_q.push_back(e);
         end
         if (cmp) begin
            m_last_slot = 2'(cur);
            m_cnt++;
            m_win++;
            m_pos = 0;
         end else begin
            m_pos++;
         end
         m_val = m_val + 16'd1;
      end
      nu = m_used + (cmp ? 1 : 0) - (rel_eff ? 1 : 0);
      if (m_wait) begin
         if (m_used < NS) m_wait = 1'b0;
      end else if (cmp && nu >= NS) begin
         m_wait = 1'b1;
      end
      m_used = nu;
   endtask

   // Monitor: every RAM strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst) begin
         if (mem_wr_en) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write: got write addr=%0h data=%0h required no write", mem_wr_addr, mem_wr_data);
            end else begin
               mon_e = exp_q.pop_front();
               chk("wr_addr",   64'(mem_wr_addr), 64'(mon_e.addr));
               chk("wr_data",   64'(mem_wr_data), 64'(mon_e.data));
               chk("seq_done",  64'(seq_done),    64'(mon_e.done));
               chk("seq_slot",  64'(seq_slot),    64'(mon_e.slot));
               chk("seq_count", 64'(seq_count),   64'(mon_e.cnt));
            end
         end else begin
            chk("seq_done_without_write", 64'(seq_done), 64'd0);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      #12;
      check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // First window, value = index: addresses 0..511, completion in slot 0.
      m_val = 16'd0;
      for (int i = 0; i < W; i++) step(1'b1, 1'b0);

      // Two more windows with no release fill the ring; further valid samples must not be accepted.
      for (int i = 0; i < 2 * W; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0);

      // Free one slot; the next window wraps to slot 0 and finishes with a coincident release.
      step(1'b1, 1'b1);
      for (int k = 0; k < W + 16 && !(m_pos == W - 1 && !m_wait); k++) step(1'b1, 1'b0);
      chk("pre_coincident_used", 64'(m_used), 64'd2);
      step(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0);

      // Drain the ring, then release against an empty ring.
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1);

      // Random valid gaps and random releases.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 8));
      end

      // Run to 301 samples into a window, then reset mid-pair.
      for (int k = 0; k < 2 * W + 100 && m_pos != 301; k++) step(1'b1, (m_used == NS));
      chk("mid_window_pos", 64'(m_pos), 64'd301);
      @(negedge clk);
      #1;
      chk("queue_empty_before_reset", 64'(exp_q.size()), 64'd0);
      rst          = 1'b0;
      sample_valid = 1'b0;
      seq_release  = 1'b0;
      #1;
      check_reset_outputs("midrst");
      model_reset();
      @(negedge clk);
      rst = 1'b1;

      // After reset, writing restarts at slot 0, word 0.
      for (int i = 0; i < W + 4; i++) step(1'b1, 1'b0);

      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
